// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) helpers and the InvMixColumns FSM encoding
package aes_pkg;
  typedef logic [127:0] state_t;
  typedef logic [31:0] col_t;
  typedef logic [7:0] byte_t;
  localparam byte_t AES_POLY = 8'h1b;
  typedef enum logic [1:0] {IDLE, RUN, DONE} imc_state_e;
  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
  // constant multipliers 09/0b/0d/0e are sums of b, 2b, 4b, 8b
  function automatic byte_t gmul(byte_t b, logic [3:0] c);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction
endpackage

// File: rtl/inv_mixcolumn.sv
// inv_mixcolumn: combinational InvMixColumns of one 32-bit column, a0 in the MSB
module inv_mixcolumn
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  byte_t a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = a;
  assign y = {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
endmodule

// File: rtl/inv_mixcolumns_seq.sv
// inv_mixcolumns_seq: column-serial InvMixColumns engine, NCOL columns per cycle, valid/ready on both sides
module inv_mixcolumns_seq
  import aes_pkg::*;
#(
  parameter int NCOL = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  if (NCOL != 1 && NCOL != 2 && NCOL != 4) begin : g_bad_ncol
    $error("inv_mixcolumns_seq: NCOL must be 1, 2 or 4");
  end
  imc_state_e st, nst;
  logic [1:0] col_idx;
  state_t sreg;
  col_t cols [4];
  col_t ncols [4];
  col_t cin [NCOL];
  col_t cout [NCOL];
  logic [1:0] ci [NCOL];
  logic accept, last;
  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign cols[c] = sreg[127-32*c -: 32];
  end
  for (genvar g = 0; g < NCOL; g++) begin : g_mix
    assign ci[g] = col_idx + 2'(g);
    assign cin[g] = cols[ci[g]];
    inv_mixcolumn u_col (.a(cin[g]), .y(cout[g]));
  end
  always_comb begin
    ncols = cols;
    for (int k = 0; k < NCOL; k++) ncols[ci[k]] = cout[k];
  end
  assign in_ready = (st == IDLE) || (st == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign last = col_idx == 2'(4 - NCOL);
  assign out_valid = st == DONE;
  assign busy = st != IDLE;
  assign out_state = sreg;
  always_comb begin
    nst = st;
    case (st)
      IDLE: nst = accept ? RUN : IDLE;
      RUN: nst = last ? DONE : RUN;
      DONE: nst = out_ready ? (in_valid ? RUN : IDLE) : DONE;
      default: nst = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      col_idx <= '0;
      sreg <= '0;
    end else begin
      st <= nst;
      if (accept) begin
        sreg <= in_state;
        col_idx <= '0;
      end else if (st == RUN) begin
        sreg <= {ncols[0], ncols[1], ncols[2], ncols[3]};
        col_idx <= col_idx + 2'(NCOL);
      end
    end
  end
endmodule

// File: tb/tb_inv_mixcolumns_seq.sv
// tb_inv_mixcolumns_seq: randomized checks of three engines (NCOL=1,2,4) against a matrix-multiply model
module tb_inv_mixcolumns_seq;
  localparam logic [31:0] INV_C = 32'h0e0b0d09;
  localparam logic [31:0] FWD_C = 32'h02030101;
  logic clk = 0;
  logic reset_n = 0;
  logic in_valid [3];
  logic in_ready [3];
  logic out_valid [3];
  logic out_ready [3];
  logic busy [3];
  logic [127:0] in_state [3];
  logic [127:0] out_state [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mixcolumns_seq #(.NCOL(1 << g)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_state(in_state[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_state(out_state[g]),
      .busy(busy[g]));
  end
  // generic GF(2^8) product by shift-and-add
  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // circulant matrix product on every column; coef holds the first matrix row
  function automatic logic [127:0] mix(logic [127:0] s, logic [31:0] coef);
    logic [127:0] r;
    logic [7:0] y;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        y = 8'h00;
        for (int j = 0; j < 4; j++)
          y ^= gm(coef[31-8*((j-i)&3) -: 8], s[127-32*c-8*j -: 8]);
        r[127-32*c-8*i -: 8] = y;
      end
    return r;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic send(input int d, input logic [127:0] s, output logic ok);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_state[d] = s;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready[d];
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask
  task automatic recv(input int d, output logic [127:0] r, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    r = out_state[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks += 4;
      if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL rst_out_valid d%0d got %b want 0", d, out_valid[d]); end
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL rst_busy d%0d got %b want 0", d, busy[d]); end
      if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL rst_in_ready d%0d got %b want 1", d, in_ready[d]); end
      if (out_state[d] !== 128'h0) begin errors++; $display("FAIL rst_out_state d%0d got %h want 0", d, out_state[d]); end
    end
  endtask
  task automatic test_vector(input int d);
    logic ok;
    logic [127:0] r;
    int lat;
    send(d, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, ok);
    recv(d, r, lat);
    checks += 3;
    if (ok !== 1'b1) begin errors++; $display("FAIL vec_accept d%0d got %b want 1", d, ok); end
    if (r !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin errors++; $display("FAIL vec_result d%0d got %h want %h", d, r, 128'hdb135345_f20a225c_01010101_c6c6c6c6); end
    if (lat != (4 >> d)) begin errors++; $display("FAIL vec_latency d%0d got %0d want %0d", d, lat, 4 >> d); end
  endtask
  task automatic test_random_model(input int d, input int n);
    logic ok;
    logic [127:0] x, r, e;
    int lat;
    for (int i = 0; i < n; i++) begin
      x = rnd128();
      e = mix(x, INV_C);
      send(d, x, ok);
      recv(d, r, lat);
      checks += 2;
      if (r !== e) begin errors++; $display("FAIL model d%0d in %h got %h want %h", d, x, r, e); end
      if (lat != (4 >> d)) begin errors++; $display("FAIL model_latency d%0d got %0d want %0d", d, lat, 4 >> d); end
    end
  endtask
  task automatic test_roundtrip(input int d, input int n);
    logic ok;
    logic [127:0] x, r;
    int lat;
    for (int i = 0; i < n; i++) begin
      x = rnd128();
      send(d, mix(x, FWD_C), ok);
      recv(d, r, lat);
      checks++;
      if (r !== x) begin errors++; $display("FAIL roundtrip d%0d got %h want %h", d, r, x); end
    end
  endtask
  task automatic test_backpressure(input int d);
    logic ok;
    logic [127:0] a, b, held, r;
    int n, lat;
    a = rnd128();
    b = rnd128();
    send(d, a, ok);
    n = 0;
    while (!out_valid[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    held = out_state[d];
    checks++;
    if (held !== mix(a, INV_C)) begin errors++; $display("FAIL bp_result got %h want %h", held, mix(a, INV_C)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_state[d] !== held) begin errors++; $display("FAIL bp_stable cyc %0d got %h want %h", i, out_state[d], held); end
      if (in_ready[d] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready[d]); end
      if (out_valid[d] !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc %0d got %b want 1", i, out_valid[d]); end
    end
    in_valid[d] = 1'b1;
    in_state[d] = b;
    out_ready[d] = 1'b1;
    #1;
    checks++;
    if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready[d]); end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b0;
    checks += 2;
    if (busy[d] !== 1'b1) begin errors++; $display("FAIL bp_reaccept_busy got %b want 1", busy[d]); end
    if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL bp_reaccept_valid got %b want 0", out_valid[d]); end
    recv(d, r, lat);
    checks++;
    if (r !== mix(b, INV_C)) begin errors++; $display("FAIL bp_second got %h want %h", r, mix(b, INV_C)); end
  endtask
  task automatic test_back_to_back(input int d);
    logic [127:0] q [$];
    logic [127:0] e;
    logic newin;
    int last_t, nout, per;
    per = (4 >> d) + 1;
    last_t = -1;
    nout = 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    in_state[d] = rnd128();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      newin = 1'b0;
      if (in_valid[d] && in_ready[d]) begin
        q.push_back(mix(in_state[d], INV_C));
        newin = 1'b1;
      end
      if (out_valid[d] && out_ready[d]) begin
        e = (q.size() > 0) ? q.pop_front() : 128'hx;
        checks++;
        if (out_state[d] !== e) begin errors++; $display("FAIL b2b_result d%0d got %h want %h", d, out_state[d], e); end
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t != per) begin errors++; $display("FAIL b2b_interval d%0d got %0d want %0d", d, cyc - last_t, per); end
        end
        last_t = cyc;
        nout++;
      end
      @(posedge clk); #1;
      if (newin) in_state[d] = rnd128();
    end
    in_valid[d] = 1'b0;
    checks++;
    if (nout < 60 / per - 2) begin errors++; $display("FAIL b2b_count d%0d got %0d want >= %0d", d, nout, 60 / per - 2); end
    repeat (8) @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
  endtask
  task automatic test_reset_mid_run(input int d);
    logic ok;
    logic [127:0] r;
    int lat;
    send(d, rnd128() | 128'h1, ok);
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (busy[d] !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy[d]); end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid[d]); end
    if (busy[d] !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy[d]); end
    if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready[d]); end
    if (out_state[d] !== 128'h0) begin errors++; $display("FAIL mid_out_state got %h want 0", out_state[d]); end
    #2;
    reset_n = 1'b1;
    send(d, 128'hd5d5d7d6_4d7ebdf8_00000000_00000000, ok);
    recv(d, r, lat);
    checks += 2;
    if (r !== 128'hd4d4d4d5_2d26314c_00000000_00000000) begin errors++; $display("FAIL mid_next got %h want %h", r, 128'hd4d4d4d5_2d26314c_00000000_00000000); end
    if (lat != (4 >> d)) begin errors++; $display("FAIL mid_latency got %0d want %0d", lat, 4 >> d); end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b0;
      in_state[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    test_reset();
    for (int d = 0; d < 3; d++) begin
      test_vector(d);
      test_random_model(d, 100);
      test_roundtrip(d, 1000);
      test_back_to_back(d);
    end
    test_backpressure(0);
    test_backpressure(2);
    test_reset_mid_run(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
